// File: rtl/rvfi_mem_model.sv
// rvfi_mem_model: request/ready memory responder for riscv-formal core wrappers.
// Serves one request at a time with bounded latency. A small backing store with
// per-word known bits returns written data. Unknown or out-of-window words return
// rand_rdata. A sticky proto_err flags requester handshake violations.
// Optional feature: define MEM_STALL_EN to add 0..MAX_STALL extra cycles per request,
// taken from rand_stall.
module rvfi_mem_model #(
    parameter int unsigned         ADDR_W    = 32,
    parameter int unsigned         DATA_W    = 32,
    parameter int unsigned         DEPTH     = 16,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter int unsigned         LATENCY   = 1,
    parameter int unsigned         MAX_STALL = 3,
    localparam int unsigned        STRB_W    = DATA_W / 8,
    localparam int unsigned        STALL_W   = $clog2(MAX_STALL + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic                mem_instr,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [STRB_W-1:0]   mem_wstrb,
    output logic                mem_ready,
    output logic [DATA_W-1:0]   mem_rdata,
    input  logic [DATA_W-1:0]   rand_rdata,
    input  logic [STALL_W-1:0]  rand_stall,
    output logic                proto_err
);

    localparam int unsigned OFF_W = $clog2(STRB_W);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + MAX_STALL + 1);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * STRB_W);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    state_t            state;
    req_t              req_q;
    req_t              req_in;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  stall;
    logic [DATA_W-1:0] store [DEPTH];
    logic [DEPTH-1:0]  known;
    logic [ADDR_W:0]   off;
    logic [IDX_W-1:0]  idx;
    logic              in_win;
    logic              is_wr;
    logic              full_wr;

    assign req_in = {mem_instr, mem_addr, mem_wdata, mem_wstrb};

`ifdef MEM_STALL_EN
    // Extra stall cycles from the formal input, saturated at MAX_STALL.
    always_comb begin
        stall = CNT_W'(rand_stall);
        if (rand_stall > STALL_W'(MAX_STALL)) stall = CNT_W'(MAX_STALL);
    end
`else
    logic unused_rand_stall;
    assign unused_rand_stall = ^rand_stall;
    assign stall = '0;
`endif

    // Window decode of the latched address; the extra top bit keeps addresses below BASE_ADDR out.
    assign off     = {1'b0, req_q.addr} - {1'b0, BASE_ADDR};
    assign in_win  = off < SPAN;
    assign idx     = off[OFF_W +: IDX_W];
    assign is_wr   = |req_q.wstrb;
    assign full_wr = &req_q.wstrb;

    // Read data is formed in the RESP cycle itself so rand_rdata is sampled there.
    always_comb begin
        mem_rdata = '0;
        if (state == RESP && !is_wr) begin
            mem_rdata = (in_win && known[idx]) ? store[idx] : rand_rdata;
        end
    end

    // Request FSM: accept, count down latency plus stall, one-cycle ready strobe, protocol checks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= '0;
            cnt       <= '0;
            known     <= '0;
            mem_ready <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (mem_valid) begin
                        req_q <= req_in;
                        cnt   <= CNT_W'(LATENCY - 1) + stall;
                        state <= WAIT;
                        if (mem_instr && (|mem_wstrb)) proto_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!mem_valid || (req_in != req_q)) proto_err <= 1'b1;
                    if (cnt == '0) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                    if (is_wr && in_win && full_wr) known[idx] <= 1'b1;
                end
                default: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Byte-merge write into the backing store at the end of RESP; the array itself is not reset.
    always_ff @(posedge clock) begin
        if (!reset && state == RESP && is_wr && in_win) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (req_q.wstrb[b]) store[idx][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
            end
        end
    end

endmodule
